// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 membrane keypad column scanner with row sampling,
// scan-level debounce and a single decoded-key output (c/r active-low
// one-hot, key_code, key_valid strobe, key_held level).
// Optional build macro KEYPAD_GHOST_REJECT_EN: when defined, any scan that
// sees two or more pressed keys yields no candidate at all.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drv,
    output logic [3:0] c,
    output logic [3:0] r,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB        = 4'(DEBOUNCE_SCANS);
    // Candidate encoding: {none, code}; NONE is normalised so compares are exact.
    localparam logic [4:0]     CAND_NONE  = 5'h10;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    state_t          state;
    logic [DW-1:0]   dwell;
    logic [1:0]      col;
    logic [1:0]      col_next;
    logic            sample;
    logic            scan_done;

    logic [3:0]      col_pressed;
    logic            col_hit;
    logic [1:0]      col_row;

    logic            acc_found;
    logic [3:0]      acc_code;
    logic            merged_found;
    logic [3:0]      merged_code;
    logic [4:0]      cand;
    logic            cand_none;

    logic [4:0]      prev_cand;
    logic [3:0]      stable_cnt;
    logic [3:0]      stable_next;

    assign sample    = (dwell == DWELL_LAST);
    assign scan_done = sample && (col == 2'd3);
    assign col_next  = col + 2'd1;

    // Column dwell counter and registered active-low column drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell   <= '0;
            col     <= 2'd0;
            col_drv <= 4'b1110;
        end else if (sample) begin
            dwell   <= '0;
            col     <= col_next;
            col_drv <= ~(4'b0001 << col_next);
        end else begin
            dwell   <= dwell + DW'(1);
        end
    end

    // Decode the rows of the currently driven column; lowest row wins.
    always_comb begin
        col_pressed = ~row_in;
        col_hit     = |col_pressed;
        if (col_pressed[0])      col_row = 2'd0;
        else if (col_pressed[1]) col_row = 2'd1;
        else if (col_pressed[2]) col_row = 2'd2;
        else                     col_row = 2'd3;
        // Columns are visited in ascending order, so the first hit is the lowest code.
        merged_found = acc_found | col_hit;
        merged_code  = acc_found ? acc_code : {col, col_row};
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic acc_multi;
    logic col_multi;
    logic merged_multi;

    // Track whether two or more keys were seen anywhere in the scan.
    always_comb begin
        col_multi    = (col_pressed & (col_pressed - 4'd1)) != 4'd0;
        merged_multi = acc_multi | col_multi | (acc_found & col_hit);
        cand_none    = !merged_found || merged_multi;
    end

    // Multi-key flag accumulates over one scan and clears at scan end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc_multi <= 1'b0;
        else if (sample)
            acc_multi <= scan_done ? 1'b0 : merged_multi;
    end
`else
    assign cand_none = !merged_found;
`endif

    assign cand = cand_none ? CAND_NONE : {1'b0, merged_code};

    // Lowest pressed key seen so far in the current scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_found <= 1'b0;
            acc_code  <= 4'd0;
        end else if (sample) begin
            acc_found <= scan_done ? 1'b0 : merged_found;
            acc_code  <= scan_done ? 4'd0 : merged_code;
        end
    end

    // Run length of identical scan candidates, saturating at 15.
    always_comb begin
        if (cand != prev_cand)
            stable_next = 4'd1;
        else if (stable_cnt == 4'd15)
            stable_next = 4'd15;
        else
            stable_next = stable_cnt + 4'd1;
    end

    // Previous candidate and its stability count, updated once per scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_cand  <= CAND_NONE;
            stable_cnt <= 4'd0;
        end else if (scan_done) begin
            prev_cand  <= cand;
            stable_cnt <= stable_next;
        end
    end

    // Debounce FSM with registered key outputs; advances only at scan end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            c         <= 4'hF;
            r         <= 4'hF;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE, DEB_PRESS: begin
                        if (cand_none) begin
                            state <= IDLE;
                        end else if (stable_next >= DEB) begin
                            state     <= PRESSED;
                            key_code  <= merged_code;
                            c         <= ~(4'b0001 << merged_code[3:2]);
                            r         <= ~(4'b0001 << merged_code[1:0]);
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else if (state == DEB_PRESS && cand != prev_cand) begin
                            state <= IDLE;
                        end else begin
                            state <= DEB_PRESS;
                        end
                    end
                    PRESSED, DEB_RELEASE: begin
                        if (cand == {1'b0, key_code}) begin
                            state <= PRESSED;
                        end else if (cand_none && stable_next >= DEB) begin
                            state    <= IDLE;
                            c        <= 4'hF;
                            r        <= 4'hF;
                            key_held <= 1'b0;
                        end else begin
                            // A different key must first be released.
                            state <= DEB_RELEASE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scan table plus randomized scans checked
// against a scan-level reference model of the debounce rules.
module tb_keypad_scanner;

    localparam int D    = 2;
    localparam int NONE = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_drv, c, r, key_code;
    logic       key_valid, key_held;
    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .col_drv(col_drv),
        .c(c), .r(r), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a row goes low when a pressed key sits in a column driven low.
    always_comb begin
        row_in = 4'hF;
        for (int ci = 0; ci < 4; ci++)
            for (int ri = 0; ri < 4; ri++)
                if (keys[ci*4+ri] && !col_drv[ci]) row_in[ri] = 1'b0;
    end

    // Scan-level reference model.
    int         m_prev;
    int         m_run;
    bit         m_held;
    logic [3:0] m_code;
    bit         m_valid;

    function automatic int cand_of(input logic [15:0] m);
        int n = 0;
        int low = NONE;
        for (int i = 15; i >= 0; i--)
            if (m[i]) begin n++; low = i; end
`ifdef KEYPAD_GHOST_REJECT_EN
        if (n >= 2) low = NONE;
`endif
        return low;
    endfunction

    task automatic model_reset();
        m_prev = NONE; m_run = 0; m_held = 0; m_code = 4'd0; m_valid = 0;
    endtask

    task automatic model_scan(input logic [15:0] m);
        int x;
        x = cand_of(m);
        if (x == m_prev) m_run++;
        else begin m_prev = x; m_run = 1; end
        m_valid = 0;
        if (!m_held) begin
            if (x != NONE && m_run >= D) begin
                m_held = 1; m_code = 4'(x); m_valid = 1;
            end
        end else if (x == NONE && m_run >= D) begin
            m_held = 0;
        end
    endtask

    function automatic logic [13:0] pack_exp(input bit v, input logic [3:0] code, input bit held);
        logic [3:0] ec, er;
        ec = held ? ~(4'b0001 << code[3:2]) : 4'hF;
        er = held ? ~(4'b0001 << code[1:0]) : 4'hF;
        return {v, code, ec, er, held};
    endfunction

    task automatic cmp(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got v/code/c/r/held=%b_%h_%b_%b_%b want %b_%h_%b_%b_%b", name,
                     act[13], act[12:9], act[8:5], act[4:1], act[0],
                     exp[13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic cmp1(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    // Apply one full scan (16 clocks) starting just after a scan boundary.
    task automatic run_scan(input logic [15:0] mask, input string name);
        bit spur = 0;
        keys = mask;
        repeat (15) begin
            @(negedge clk);
            if (key_valid !== 1'b0) spur = 1;
        end
        @(negedge clk);
        cmp1({name, "_nopulse_midscan"}, {3'b0, spur}, 4'b0);
    endtask

    function automatic logic [13:0] actual();
        return {key_valid, key_code, c, r, key_held};
    endfunction

    // Release reset at a negedge, check the column sequence and first scan.
    task automatic release_reset();
        keys = 16'h0000;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            cmp1($sformatf("col_drv_%0d", i), col_drv, ~(4'b0001 << (i / 4)));
        end
        @(negedge clk);
        model_scan(16'h0000);
        cmp("first_scan", actual(), pack_exp(m_valid, m_code, m_held));
    endtask

    typedef struct {
        logic [15:0] mask;
        bit          v;
        logic [3:0]  code;
        bit          held;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [15:0] m, input bit v, input logic [3:0] code, input bit held);
        vec_t t;
        t.mask = m; t.v = v; t.code = code; t.held = held;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [15:0] rmask;
        int sel;

        // Clean press of code 9, held for 10 more scans, then release.
        add(16'h0200, 0, 4'd0, 0);
        add(16'h0200, 1, 4'd9, 1);
        for (int i = 0; i < 10; i++) add(16'h0200, 0, 4'd9, 1);
        add(16'h0000, 0, 4'd9, 1);
        add(16'h0000, 0, 4'd9, 0);
        // Bounce on code 0.
        for (int i = 0; i < 8; i++) add((i % 2 == 0) ? 16'h0001 : 16'h0000, 0, 4'd9, 0);
        // Rollover 9 -> 15 without release, then release and press 15.
        add(16'h0200, 0, 4'd9, 0);
        add(16'h0200, 1, 4'd9, 1);
        for (int i = 0; i < 3; i++) add(16'h8000, 0, 4'd9, 1);
        add(16'h0000, 0, 4'd9, 1);
        add(16'h0000, 0, 4'd9, 0);
        add(16'h8000, 0, 4'd9, 0);
        add(16'h8000, 1, 4'd15, 1);
        add(16'h0000, 0, 4'd15, 1);
        add(16'h0000, 0, 4'd15, 0);
        // Keys 0 and 5 together.
`ifdef KEYPAD_GHOST_REJECT_EN
        for (int i = 0; i < 3; i++) add(16'h0021, 0, 4'd15, 0);
        add(16'h0000, 0, 4'd15, 0);
        add(16'h0000, 0, 4'd15, 0);
`else
        add(16'h0021, 0, 4'd15, 0);
        add(16'h0021, 1, 4'd0, 1);
        add(16'h0021, 0, 4'd0, 1);
        add(16'h0000, 0, 4'd0, 1);
        add(16'h0000, 0, 4'd0, 0);
`endif

        model_reset();
        repeat (3) @(negedge clk);
        cmp("reset_outputs", {key_valid, key_code, c, r, key_held}, {1'b0, 4'd0, 4'hF, 4'hF, 1'b0});
        release_reset();

        foreach (vecs[i]) begin
            run_scan(vecs[i].mask, $sformatf("vec%0d", i));
            model_scan(vecs[i].mask);
            cmp($sformatf("vec%0d", i), actual(), pack_exp(vecs[i].v, vecs[i].code, vecs[i].held));
            $display("scan vec%0d mask=%h valid=%b code=%0d c=%b r=%b held=%b",
                     i, vecs[i].mask, key_valid, key_code, c, r, key_held);
        end

        // Mid-scan asynchronous reset while a key is held.
        for (int i = 0; i < 2; i++) begin
            run_scan(16'h0008, "hold3");
            model_scan(16'h0008);
            cmp($sformatf("hold3_%0d", i), actual(), pack_exp(m_valid, m_code, m_held));
        end
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("midscan_reset_outputs", actual(), {1'b0, 4'd0, 4'hF, 4'hF, 1'b0});
        cmp1("midscan_reset_col_drv", col_drv, 4'b1110);
        @(negedge clk);
        model_reset();
        release_reset();

        // Randomized scans against the reference model.
        rmask = 16'h0000;
        for (int i = 0; i < 48; i++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 6)      rmask = 16'h0000;
            else if (sel == 7 || sel == 8) rmask = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 9)             rmask = (16'h0001 << $urandom_range(0, 15)) |
                                                   (16'h0001 << $urandom_range(0, 15));
            run_scan(rmask, $sformatf("rnd%0d", i));
            model_scan(rmask);
            cmp($sformatf("rnd%0d", i), actual(), pack_exp(m_valid, m_code, m_held));
            $display("scan rnd%0d mask=%h valid=%b code=%0d held=%b", i, rmask, key_valid, key_code, key_held);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
